// File: rtl/emac_dma_sched.sv
// Two-channel round-robin DMA scheduler for the EMAC buffer (ch0 TX writes, ch1 RX reads).
// Optional watchdog abort on stalled REQ/XFER when EMAC_DMA_TIMEOUT_EN is defined.
module emac_dma_sched #(
    parameter int LEN_WIDTH   = 11,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 sysclk_i,
    input  logic                 reset_i,
    input  logic                 tx_start_i,
    input  logic [LEN_WIDTH-1:0] tx_len_i,
    input  logic                 rx_rdy_i,
    input  logic [LEN_WIDTH-1:0] rx_len_i,
    input  logic [1:0]           grant_dma_i,
    input  logic                 dma_req_wr_i,
    input  logic                 dma_req_rd_i,
    output logic [1:0]           req_dma_o,
    output logic [1:0]           hold_dma_o,
    output logic                 tx_busy_o,
    output logic                 rx_busy_o,
    output logic                 tx_done_o,
    output logic                 rx_done_o,
    output logic                 dma_err_o
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    if (MAX_BURST < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("emac_dma_sched: MAX_BURST and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_DONE,
        S_REL
    } state_t;

    state_t               state, state_nx;
    logic                 ch, ch_nx;
    logic                 rr_last, rr_last_nx;
    logic                 tx_pend, tx_pend_nx;
    logic [LEN_WIDTH-1:0] tx_rem, tx_rem_nx;
    logic                 rx_act, rx_act_nx;
    logic [LEN_WIDTH-1:0] rx_rem, rx_rem_nx;
    logic [BW-1:0]        burst, burst_nx;

    logic                 pick;
    logic [LEN_WIDTH-1:0] pick_rem;
    logic [LEN_WIDTH-1:0] cur_rem;
    logic                 ack;
    logic                 grant;
    logic                 tmo_hit;

    // Tie-break favours the channel not served last; a lone pending channel always wins.
    assign pick     = (tx_pend && rx_act) ? ~rr_last : rx_act;
    assign pick_rem = pick ? rx_rem : tx_rem;
    assign cur_rem  = ch ? rx_rem : tx_rem;
    assign ack      = ch ? dma_req_rd_i : dma_req_wr_i;
    assign grant    = grant_dma_i[ch];

`ifdef EMAC_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_active;
    logic          tmo_kick;
    logic          err_q;

    assign tmo_active = (state == S_REQ) || (state == S_XFER);
    assign tmo_kick   = grant || ((state == S_XFER) && ack);
    assign tmo_hit    = tmo_active && !tmo_kick && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sysclk_i or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (!tmo_active || tmo_kick || (state_nx != state)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign dma_err_o = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign dma_err_o = 1'b0;
`endif

    always_ff @(posedge sysclk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= S_IDLE;
            ch      <= 1'b0;
            rr_last <= 1'b1;
            tx_pend <= 1'b0;
            tx_rem  <= '0;
            rx_act  <= 1'b0;
            rx_rem  <= '0;
            burst   <= '0;
        end else begin
            state   <= state_nx;
            ch      <= ch_nx;
            rr_last <= rr_last_nx;
            tx_pend <= tx_pend_nx;
            tx_rem  <= tx_rem_nx;
            rx_act  <= rx_act_nx;
            rx_rem  <= rx_rem_nx;
            burst   <= burst_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        rr_last_nx = rr_last;
        tx_pend_nx = tx_pend;
        tx_rem_nx  = tx_rem;
        rx_act_nx  = rx_act;
        rx_rem_nx  = rx_rem;
        burst_nx   = burst;

        // A start while TX is pending or active is dropped, so no job is ever overwritten.
        if (tx_start_i && !tx_pend) begin
            tx_pend_nx = 1'b1;
            tx_rem_nx  = tx_len_i;
        end

        case (state)
            S_IDLE: begin
                if (rx_rdy_i && !rx_act) begin
                    rx_act_nx = 1'b1;
                    rx_rem_nx = rx_len_i;
                end
                if (tx_pend || rx_act) begin
                    ch_nx    = pick;
                    burst_nx = '0;
                    if (pick_rem == '0) begin
                        state_nx = S_DONE;
                        if (pick) rx_act_nx = 1'b0;
                        else      tx_pend_nx = 1'b0;
                    end else begin
                        state_nx = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (tmo_hit) begin
                    state_nx   = S_IDLE;
                    rr_last_nx = ch;
                    if (ch) rx_act_nx = 1'b0;
                    else    tx_pend_nx = 1'b0;
                end else if (grant) begin
                    state_nx = S_XFER;
                end
            end

            S_XFER: begin
                if (tmo_hit) begin
                    state_nx   = S_IDLE;
                    rr_last_nx = ch;
                    if (ch) rx_act_nx = 1'b0;
                    else    tx_pend_nx = 1'b0;
                end else if (ack) begin
                    burst_nx = burst + 1'b1;
                    if (ch) rx_rem_nx = rx_rem - 1'b1;
                    else    tx_rem_nx = tx_rem - 1'b1;
                    if (cur_rem == LEN_WIDTH'(1)) begin
                        state_nx = S_DONE;
                        if (ch) rx_act_nx = 1'b0;
                        else    tx_pend_nx = 1'b0;
                    end else if (burst == BURST_LAST) begin
                        state_nx = S_REL;
                    end
                end
            end

            S_REL: begin
                state_nx   = S_IDLE;
                rr_last_nx = ch;
            end

            S_DONE: begin
                state_nx   = S_IDLE;
                rr_last_nx = ch;
            end

            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode only the registered state, so they drop at once on async reset.
    always_comb begin
        req_dma_o  = 2'b00;
        hold_dma_o = 2'b00;
        if ((state == S_REQ) || (state == S_XFER)) begin
            req_dma_o = ch ? 2'b10 : 2'b01;
        end
        if (state == S_XFER) begin
            hold_dma_o = ch ? 2'b10 : 2'b01;
        end
    end

    assign tx_busy_o = tx_pend;
    assign rx_busy_o = rx_act;
    assign tx_done_o = (state == S_DONE) && !ch;
    assign rx_done_o = (state == S_DONE) && ch;

endmodule

// File: tb/tb_emac_dma_sched.sv
// Scoreboard bench for emac_dma_sched: stimulus pushes expected events, a negedge monitor pops them.
module tb_emac_dma_sched;

    localparam int LW     = 11;
    localparam int EV_REQ = 0;
    localparam int EV_BST = 1;
    localparam int EV_DON = 2;
    localparam int EV_ERR = 3;

    logic          sysclk_i;
    logic          reset_i;
    logic          tx_start_i;
    logic [LW-1:0] tx_len_i;
    logic          rx_rdy_i;
    logic [LW-1:0] rx_len_i;
    logic [1:0]    grant_dma_i;
    logic          dma_req_wr_i;
    logic          dma_req_rd_i;
    logic [1:0]    req_dma_o;
    logic [1:0]    hold_dma_o;
    logic          tx_busy_o;
    logic          rx_busy_o;
    logic          tx_done_o;
    logic          rx_done_o;
    logic          dma_err_o;

    emac_dma_sched #(
        .LEN_WIDTH  (LW),
        .MAX_BURST  (16),
        .TIMEOUT_CYC(8)
    ) dut (
        .sysclk_i    (sysclk_i),
        .reset_i     (reset_i),
        .tx_start_i  (tx_start_i),
        .tx_len_i    (tx_len_i),
        .rx_rdy_i    (rx_rdy_i),
        .rx_len_i    (rx_len_i),
        .grant_dma_i (grant_dma_i),
        .dma_req_wr_i(dma_req_wr_i),
        .dma_req_rd_i(dma_req_rd_i),
        .req_dma_o   (req_dma_o),
        .hold_dma_o  (hold_dma_o),
        .tx_busy_o   (tx_busy_o),
        .rx_busy_o   (rx_busy_o),
        .tx_done_o   (tx_done_o),
        .rx_done_o   (rx_done_o),
        .dma_err_o   (dma_err_o)
    );

    typedef struct {
        int kind;
        int ch;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;

    bit  gnt_block = 1'b0;
    bit  wr_noise  = 1'b0;
    bit  rd_noise  = 1'b0;
    int  gnt_delay = 1;

    initial begin
        sysclk_i = 1'b0;
        forever #5 sysclk_i = ~sysclk_i;
    end

    always @(posedge sysclk_i) cyc <= cyc + 1;

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.ch   = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void got(input int k, input int c, input int v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected got kind=%0d ch=%0d val=%0d at cyc=%0d, none required", k, c, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.ch != c || (e.val != -1 && e.val != v)) begin
                n_fail++;
                $display("FAIL event_order got kind=%0d ch=%0d val=%0d, required kind=%0d ch=%0d val=%0d",
                         k, c, v, e.kind, e.ch, e.val);
            end
        end
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at cyc=%0d", nm, act, expv, cyc);
        end
    endtask

    // DMA controller model: grants after gnt_delay cycles of request, acks every cycle of hold.
    initial begin
        int reqc[2];
        reqc[0] = 0;
        reqc[1] = 0;
        grant_dma_i  = 2'b00;
        dma_req_wr_i = 1'b0;
        dma_req_rd_i = 1'b0;
        forever begin
            @(posedge sysclk_i);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (req_dma_o[c] && !hold_dma_o[c]) reqc[c]++;
                else                                reqc[c] = 0;
                grant_dma_i[c] = !gnt_block && (reqc[c] > gnt_delay);
            end
            dma_req_wr_i = hold_dma_o[0] || (wr_noise && !hold_dma_o[0] && (cyc % 2 == 0));
            dma_req_rd_i = hold_dma_o[1] || (rd_noise && hold_dma_o[0] && (cyc % 2 == 1));
        end
    end

    // Monitor: turns DUT activity into events and checks them against the scoreboard.
    initial begin
        int  acnt[2];
        logic [1:0] req_prev;
        logic [1:0] hold_prev;
        acnt[0]   = 0;
        acnt[1]   = 0;
        req_prev  = 2'b00;
        hold_prev = 2'b00;
        forever begin
            @(negedge sysclk_i);
            n_checks++;
            if (req_dma_o == 2'b11 || hold_dma_o == 2'b11) begin
                n_fail++;
                $display("FAIL onehot req=%b hold=%b required at most one channel", req_dma_o, hold_dma_o);
            end
            for (int c = 0; c < 2; c++) begin
                if (hold_dma_o[c]) begin
                    if ((c == 0 && dma_req_wr_i) || (c == 1 && dma_req_rd_i)) acnt[c]++;
                end else if (hold_prev[c]) begin
                    got(EV_BST, c, acnt[c]);
                    acnt[c] = 0;
                end
            end
            for (int c = 0; c < 2; c++) begin
                if (req_dma_o[c] && !req_prev[c]) got(EV_REQ, c, cyc);
            end
            if (tx_done_o) got(EV_DON, 0, cyc);
            if (rx_done_o) got(EV_DON, 1, cyc);
            if (dma_err_o) got(EV_ERR, 0, cyc);
            req_prev  = req_dma_o;
            hold_prev = hold_dma_o;
        end
    end

    task automatic issue_tx(input int len, output int n);
        @(posedge sysclk_i);
        #1;
        tx_len_i   = LW'(len);
        tx_start_i = 1'b1;
        n          = cyc;
        @(posedge sysclk_i);
        #1;
        tx_start_i = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge sysclk_i);
            k++;
        end
        repeat (4) @(negedge sysclk_i);
        chk({nm, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        int k;
        reset_i    = 1'b0;
        tx_start_i = 1'b0;
        tx_len_i   = '0;
        rx_rdy_i   = 1'b0;
        rx_len_i   = '0;

        repeat (3) @(negedge sysclk_i);
        chk("rst_req", req_dma_o, 0);
        chk("rst_hold", hold_dma_o, 0);
        chk("rst_tx_busy", tx_busy_o, 0);
        chk("rst_rx_busy", rx_busy_o, 0);
        chk("rst_tx_done", tx_done_o, 0);
        chk("rst_rx_done", rx_done_o, 0);
        chk("rst_err", dma_err_o, 0);
        @(posedge sysclk_i);
        #1;
        reset_i = 1'b1;
        repeat (2) @(posedge sysclk_i);

        // TX and RX arrive together: TX wins the first tie, then strict alternation.
        @(posedge sysclk_i);
        #1;
        tx_len_i   = LW'(20);
        tx_start_i = 1'b1;
        rx_len_i   = LW'(20);
        rx_rdy_i   = 1'b1;
        n          = cyc;
        push(EV_REQ, 0, n + 2);
        push(EV_BST, 0, 16);
        push(EV_REQ, 1, -1);
        push(EV_BST, 1, 16);
        push(EV_REQ, 0, -1);
        push(EV_BST, 0, 4);
        push(EV_DON, 0, -1);
        push(EV_REQ, 1, -1);
        push(EV_BST, 1, 4);
        push(EV_DON, 1, -1);
        @(posedge sysclk_i);
        #1;
        tx_start_i = 1'b0;
        rx_rdy_i   = 1'b0;
        @(negedge sysclk_i);
        chk("rr_tx_busy", tx_busy_o, 1);
        chk("rr_rx_busy", rx_busy_o, 1);
        drain("rr", 400);
        chk("rr_rx_busy_end", rx_busy_o, 0);

        // Single short TX: req at N+2, grant one cycle later, done after the 5th ack.
        issue_tx(5, n);
        push(EV_REQ, 0, n + 2);
        push(EV_BST, 0, 5);
        push(EV_DON, 0, n + 9);
        drain("tx5", 200);
        chk("tx5_busy_end", tx_busy_o, 0);

        // Long TX split into capped bursts.
        issue_tx(40, n);
        push(EV_REQ, 0, n + 2);
        push(EV_BST, 0, 16);
        push(EV_REQ, 0, -1);
        push(EV_BST, 0, 16);
        push(EV_REQ, 0, -1);
        push(EV_BST, 0, 8);
        push(EV_DON, 0, -1);
        drain("tx40", 400);

        // Stray RX acks during the TX burst and stray TX acks outside XFER.
        rd_noise = 1'b1;
        wr_noise = 1'b1;
        issue_tx(3, n);
        push(EV_REQ, 0, n + 2);
        push(EV_BST, 0, 3);
        push(EV_DON, 0, n + 7);
        drain("noise", 200);
        rd_noise = 1'b0;
        wr_noise = 1'b0;

        // Zero-length TX, with a second start held over the busy cycle.
        @(posedge sysclk_i);
        #1;
        tx_len_i   = LW'(0);
        tx_start_i = 1'b1;
        n          = cyc;
        push(EV_DON, 0, n + 2);
        @(posedge sysclk_i);
        #1;
        tx_len_i = LW'(3);
        @(negedge sysclk_i);
        chk("zero_busy_n1", tx_busy_o, 1);
        @(posedge sysclk_i);
        #1;
        tx_start_i = 1'b0;
        @(negedge sysclk_i);
        chk("zero_busy_n2", tx_busy_o, 0);
        drain("zero", 50);
        chk("zero_busy_end", tx_busy_o, 0);

        // Grant withheld.
        gnt_block = 1'b1;
        issue_tx(4, n);
        push(EV_REQ, 0, n + 2);
`ifdef EMAC_DMA_TIMEOUT_EN
        push(EV_ERR, 0, n + 10);
        repeat (20) @(negedge sysclk_i);
        chk("tmo_req", req_dma_o, 0);
        chk("tmo_busy", tx_busy_o, 0);
        gnt_block = 1'b0;
        drain("tmo", 50);
`else
        repeat (20) @(negedge sysclk_i);
        chk("stall_req", req_dma_o, 1);
        chk("stall_busy", tx_busy_o, 1);
        chk("stall_err", dma_err_o, 0);
        push(EV_BST, 0, 4);
        push(EV_DON, 0, -1);
        gnt_block = 1'b0;
        drain("stall", 100);
`endif

        // Async reset in the middle of a burst.
        issue_tx(10, n);
        push(EV_REQ, 0, n + 2);
        k = 0;
        while (!hold_dma_o[0] && k < 50) begin
            @(negedge sysclk_i);
            k++;
        end
        chk("areset_hold_seen", hold_dma_o[0], 1);
        push(EV_BST, 0, 2);
        @(posedge sysclk_i);
        @(posedge sysclk_i);
        #3;
        reset_i = 1'b0;
        #1;
        chk("areset_req", req_dma_o, 0);
        chk("areset_hold", hold_dma_o, 0);
        chk("areset_busy", tx_busy_o, 0);
        repeat (2) @(posedge sysclk_i);
        #1;
        reset_i = 1'b1;
        drain("areset", 50);
        repeat (10) @(negedge sysclk_i);
        chk("areset_idle_req", req_dma_o, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
